// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_pkg
//  Description : Constants and FSM state type shared by the 3x3 convolution
//                sequencer, the accelerator and the host register block.
//  Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

  localparam int DW        = 32;  // Q8.24 data word
  localparam int NUM_TAPS  = 9;   // words per filter and per window
  localparam int FRAC_BITS = 24;  // fractional bits of the Q8.24 format

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_COEF = 3'd1,
    S_FEED      = 3'd2,
    S_WAIT      = 3'd3,
    S_OUTPUT    = 3'd4,
    S_FINISH    = 3'd5
  } conv_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/conv_result_reg.sv
`default_nettype none
// ============================================================================
//  Module      : conv_result_reg
//  Description : One-entry valid/ready holding register for a window result.
//                Loaded once per window, emptied by the downstream handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_result_reg #(
  parameter int DW = conv_pkg::DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  output logic [DW-1:0] data,
  output logic          valid,
  input  logic          ready
);

  logic [DW-1:0] r_data;
  logic          r_valid;

  // Hold the captured result until the consumer takes it; data is never
  // cleared so it stays stable for the whole time valid is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_data  <= load_data;
      r_valid <= 1'b1;
    end else if (r_valid && ready) begin
      r_valid <= 1'b0;
    end
  end

  assign data  = r_data;
  assign valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/conv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : conv_sequencer
//  Description : Drives one convolution accelerator through a job: optional
//                nine-word coefficient load, then per window nine pixel words,
//                a fixed-latency wait and a result handed out on a stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_sequencer #(
  parameter int DW          = conv_pkg::DW,
  parameter int NUM_TAPS    = conv_pkg::NUM_TAPS,
  parameter int ACC_LATENCY = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfgStart,
  input  logic             cfgReloadCoef,
  input  logic [CNT_W-1:0] cfgNumWindows,
  input  logic [DW-1:0]    coefData,
  input  logic             coefValid,
  output logic             coefReady,
  input  logic [DW-1:0]    pixData,
  input  logic             pixValid,
  output logic             pixReady,
  output logic [DW-1:0]    resData,
  output logic             resValid,
  input  logic             resReady,
  output logic             busy,
  output logic             done,
  output logic [DW-1:0]    accDataIn,
  output logic             accDataValid,
  output logic             accFilter,
  input  logic [DW-1:0]    accDataOut
);
  import conv_pkg::*;

  localparam int TAP_W  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int WAIT_W = (ACC_LATENCY > 0) ? $clog2(ACC_LATENCY + 1) : 1;
  localparam logic [TAP_W-1:0]  C_LAST_TAP  = TAP_W'(NUM_TAPS - 1);
  localparam logic [WAIT_W-1:0] C_LAST_WAIT = WAIT_W'(ACC_LATENCY);
  localparam logic [CNT_W-1:0]  C_ONE_WIN   = CNT_W'(1);

  conv_seq_state_t   r_state;
  conv_seq_state_t   w_state_next;
  logic [TAP_W-1:0]  r_tap;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_windows;
  logic              r_coef_loaded;
  logic [DW-1:0]     r_acc_data;
  logic              r_acc_valid;
  logic              r_acc_filter;

  logic w_coef_hs;
  logic w_pix_hs;
  logic w_res_hs;
  logic w_tap_last;
  logic w_wait_last;
  logic w_capture;
  logic w_enter_tap_state;

  assign w_coef_hs   = coefValid & coefReady;
  assign w_pix_hs    = pixValid & pixReady;
  assign w_res_hs    = resValid & resReady;
  assign w_tap_last  = (r_tap == C_LAST_TAP);
  assign w_wait_last = (r_wait == C_LAST_WAIT);
  // The WAIT state spans ACC_LATENCY+1 cycles starting with the cycle the
  // ninth pixel sits on the accelerator, so the last one sees its result.
  assign w_capture   = (r_state == S_WAIT) && w_wait_last;
  assign w_enter_tap_state = (w_state_next != r_state) &&
                             ((w_state_next == S_LOAD_COEF) || (w_state_next == S_FEED));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic and state-decoded stream/status outputs
  always_comb begin
    w_state_next = r_state;
    coefReady    = 1'b0;
    pixReady     = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (cfgStart) begin
          if (cfgNumWindows == '0)                  w_state_next = S_FINISH;
          else if (cfgReloadCoef || !r_coef_loaded) w_state_next = S_LOAD_COEF;
          else                                      w_state_next = S_FEED;
        end
      end
      S_LOAD_COEF: begin
        coefReady = 1'b1;
        if (w_coef_hs && w_tap_last) w_state_next = S_FEED;
      end
      S_FEED: begin
        pixReady = 1'b1;
        if (w_pix_hs && w_tap_last) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_wait_last) w_state_next = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (w_res_hs) w_state_next = (r_windows == C_ONE_WIN) ? S_FINISH : S_FEED;
      end
      S_FINISH: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Tap counter: restarts on entry to LOAD_COEF/FEED and wraps after the ninth word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     r_tap <= '0;
    else if (w_enter_tap_state)     r_tap <= '0;
    else if (w_coef_hs || w_pix_hs) r_tap <= w_tap_last ? '0 : r_tap + TAP_W'(1);
  end

  // Latency counter: idles at zero outside WAIT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                r_wait <= '0;
    else if (r_state != S_WAIT) r_wait <= '0;
    else if (!w_wait_last)     r_wait <= r_wait + WAIT_W'(1);
  end

  // Window counter: loaded by an accepted start, decremented per delivered result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                r_windows <= '0;
    else if ((r_state == S_IDLE) && cfgStart)  r_windows <= cfgNumWindows;
    else if ((r_state == S_OUTPUT) && w_res_hs) r_windows <= r_windows - C_ONE_WIN;
  end

  // Coefficients stay valid in the accelerator until the next reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                 r_coef_loaded <= 1'b0;
    else if (w_coef_hs && w_tap_last)           r_coef_loaded <= 1'b1;
  end

  // Registered accelerator drive: one word per accepted handshake, data held on stalls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc_data   <= '0;
      r_acc_valid  <= 1'b0;
      r_acc_filter <= 1'b0;
    end else begin
      r_acc_valid <= w_coef_hs | w_pix_hs;
      if (w_coef_hs) begin
        r_acc_data   <= coefData;
        r_acc_filter <= 1'b1;
      end else if (w_pix_hs) begin
        r_acc_data   <= pixData;
        r_acc_filter <= 1'b0;
      end
    end
  end

  assign accDataIn    = r_acc_data;
  assign accDataValid = r_acc_valid;
  assign accFilter    = r_acc_filter;

  conv_result_reg #(
    .DW (DW)
  ) u_result_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (w_capture),
    .load_data (accDataOut),
    .data      (resData),
    .valid     (resValid),
    .ready     (resReady)
  );

endmodule
`default_nettype wire

// File: tb/tb_conv_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_conv_sequencer
//  Description : Self-checking bench for conv_sequencer with a behavioural
//                accelerator and a dot-product reference for each window.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_sequencer;
  import conv_pkg::*;

  localparam int ACC_LAT = 2;
  localparam int CW      = 16;
  localparam int MAX_WIN = 8;
  localparam int BUDGET  = 3000;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfgStart, cfgReloadCoef;
  logic [CW-1:0] cfgNumWindows;
  logic [DW-1:0] coefData, pixData, resData, accDataIn, accDataOut;
  logic          coefValid, coefReady, pixValid, pixReady;
  logic          resValid, resReady, busy, done, accDataValid, accFilter;

  always #5 clk = ~clk;

  conv_sequencer #(
    .DW(DW), .NUM_TAPS(NUM_TAPS), .ACC_LATENCY(ACC_LAT), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .cfgStart(cfgStart), .cfgReloadCoef(cfgReloadCoef),
    .cfgNumWindows(cfgNumWindows), .coefData(coefData), .coefValid(coefValid),
    .coefReady(coefReady), .pixData(pixData), .pixValid(pixValid), .pixReady(pixReady),
    .resData(resData), .resValid(resValid), .resReady(resReady), .busy(busy), .done(done),
    .accDataIn(accDataIn), .accDataValid(accDataValid), .accFilter(accFilter),
    .accDataOut(accDataOut)
  );

  // ---------------- behavioural accelerator ----------------
  logic [DW-1:0]      am_coef [NUM_TAPS];
  int                 am_fi, am_pi;
  logic signed [63:0] am_sum, am_prod, am_a, am_c;
  logic [DW-1:0]      am_pipe_d [ACC_LAT];
  logic               am_pipe_v [ACC_LAT];

  assign am_a    = {{32{accDataIn[31]}}, accDataIn};
  assign am_c    = {{32{am_coef[am_pi][31]}}, am_coef[am_pi]};
  assign am_prod = (am_a * am_c) >>> FRAC_BITS;
  // Result is only presented in its one valid cycle; garbage otherwise
  assign accDataOut = am_pipe_v[ACC_LAT-1] ? am_pipe_d[ACC_LAT-1] : 32'hDEAD_BEEF;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      am_fi  <= 0;
      am_pi  <= 0;
      am_sum <= '0;
      for (int k = 0; k < ACC_LAT; k++) begin
        am_pipe_v[k] <= 1'b0;
        am_pipe_d[k] <= '0;
      end
    end else begin
      for (int k = 1; k < ACC_LAT; k++) begin
        am_pipe_v[k] <= am_pipe_v[k-1];
        am_pipe_d[k] <= am_pipe_d[k-1];
      end
      am_pipe_v[0] <= 1'b0;
      if (accDataValid && accFilter) begin
        am_coef[am_fi] <= accDataIn;
        am_fi <= (am_fi == NUM_TAPS-1) ? 0 : am_fi + 1;
      end else if (accDataValid) begin
        if (am_pi == NUM_TAPS-1) begin
          am_pipe_v[0] <= 1'b1;
          am_pipe_d[0] <= 32'(am_sum + am_prod);
          am_sum <= '0;
          am_pi  <= 0;
        end else begin
          am_sum <= am_sum + am_prod;
          am_pi  <= am_pi + 1;
        end
      end
    end
  end

  // ---------------- reference model state ----------------
  logic [DW-1:0] m_coef   [NUM_TAPS];
  logic [DW-1:0] new_coef [NUM_TAPS];
  logic [DW-1:0] job_coef [NUM_TAPS];
  logic [DW-1:0] pix_mem  [NUM_TAPS*MAX_WIN];
  bit            m_loaded;

  int tests  = 0;
  int failed = 0;

  typedef struct {
    bit basic;
    bit reload;
    int nwin;
    int gap_pct;
    int stall;
    int extra_start;
    int abort_pix;
    int exp_coef;
  } job_t;

  job_t jobs [9];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] want);
    tests++;
    if (act !== want) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  function automatic logic [DW-1:0] rand_q(input int range);
    int r;
    r = int'($urandom_range(0, 2*range*(1<<FRAC_BITS) - 1)) - range*(1<<FRAC_BITS);
    return DW'(r);
  endfunction

  // Window result = sum over taps of coef*pixel in Q8.24 (each product floored)
  function automatic logic [DW-1:0] ref_dot(input int w);
    longint s = 0;
    for (int k = 0; k < NUM_TAPS; k++)
      s += (longint'($signed(job_coef[k])) * longint'($signed(pix_mem[w*NUM_TAPS+k]))) >>> FRAC_BITS;
    return s[31:0];
  endfunction

  task automatic run_job(input job_t v);
    int coef_idx = 0, pix_idx = 0, res_got = 0, cyc = 0;
    int acc_v = 0, acc_f = 0, busy_bad = 0, unstable = 0, done_cnt = 0, done_cyc = -1;
    int first_coef_cyc = -1, last_pix_cyc = -1, first_res_cyc = -1, stall_left;
    bit load, fin = 0, aborted = 0, prev_hold = 0;
    logic [DW-1:0] prev_res = '0;

    load = (v.nwin != 0) && (v.reload || !m_loaded);
    for (int k = 0; k < NUM_TAPS; k++)
      new_coef[k] = v.basic ? 32'h0080_0000 : rand_q(2);
    for (int w = 0; w < v.nwin; w++)
      for (int k = 0; k < NUM_TAPS; k++)
        pix_mem[w*NUM_TAPS+k] = v.basic ? (32'h0180_0000 + 32'(k) * 32'h0100_0000) : rand_q(4);
    for (int k = 0; k < NUM_TAPS; k++)
      job_coef[k] = load ? new_coef[k] : m_coef[k];
    stall_left = v.stall;

    @(negedge clk);
    cfgStart = 1'b1; cfgReloadCoef = v.reload; cfgNumWindows = CW'(v.nwin);
    while (!fin && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      cfgStart = (cyc == v.extra_start);
      if (cfgStart) begin cfgNumWindows = CW'(7); cfgReloadCoef = 1'b1; end

      if (v.abort_pix >= 0 && pix_idx == v.abort_pix) begin
        coefValid = 1'b0; pixValid = 1'b0; resReady = 1'b0;
        check("pre_reset_in_feed", pixReady, 1);
        #1 reset = 1'b0;
        #1 check("reset_outputs_async",
                 {coefReady, pixReady, resValid, resData, busy, done, accDataIn, accDataValid, accFilter}, '0);
        aborted = 1;
        break;
      end

      if (accDataValid) begin acc_v++; if (accFilter) acc_f++; end
      if (done_cnt > 0) begin
        check("busy_after_done", busy, 0);
        check("done_width", done, 0);
        fin = 1;
      end else begin
        if (!busy) busy_bad++;
        if (done) begin done_cnt++; done_cyc = cyc; end
      end

      coefValid = 1'b0;
      if (coefReady && first_coef_cyc < 0) first_coef_cyc = cyc;
      if (!fin && coef_idx < NUM_TAPS && int'($urandom_range(0, 99)) >= v.gap_pct) begin
        coefValid = 1'b1; coefData = new_coef[coef_idx];
        if (coefReady) coef_idx++;
      end

      pixValid = 1'b0;
      if (!fin && pix_idx < v.nwin*NUM_TAPS && int'($urandom_range(0, 99)) >= v.gap_pct) begin
        pixValid = 1'b1; pixData = pix_mem[pix_idx];
        if (pixReady) begin
          pix_idx++;
          if (pix_idx % NUM_TAPS == 0) last_pix_cyc = cyc;
        end
      end

      if (prev_hold && (!resValid || resData !== prev_res)) unstable++;
      resReady = 1'b0; prev_hold = 0;
      if (resValid) begin
        if (first_res_cyc < 0) first_res_cyc = cyc;
        if (stall_left > 0) begin
          stall_left--; prev_hold = 1; prev_res = resData;
        end else begin
          resReady = 1'b1;
          if (res_got < v.nwin) check($sformatf("result[%0d]", res_got), resData, ref_dot(res_got));
          if (v.basic) check("basic_value", resData, 32'h18C0_0000);
          res_got++;
          stall_left = v.stall;
        end
      end
    end
    coefValid = 1'b0; pixValid = 1'b0; resReady = 1'b0; cfgStart = 1'b0;

    if (aborted) begin
      check("coef_words_before_reset", coef_idx, v.exp_coef);
      m_loaded = 0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      return;
    end

    check("job_completed", fin, 1);
    check("coef_words", coef_idx, v.exp_coef);
    check("acc_valid_cycles", acc_v, v.exp_coef + NUM_TAPS*v.nwin);
    check("acc_filter_cycles", acc_f, v.exp_coef);
    check("result_count", res_got, v.nwin);
    check("busy_low_in_job", busy_bad, 0);
    check("res_unstable", unstable, 0);
    if (v.nwin == 0) check("zero_win_done_cycle", done_cyc, 1);
    if (v.basic) begin
      check("start_to_coefready", first_coef_cyc, 1);
      check("lastpix_to_resvalid", first_res_cyc - last_pix_cyc, ACC_LAT + 2);
    end
    if (load) begin
      for (int k = 0; k < NUM_TAPS; k++) m_coef[k] = new_coef[k];
      m_loaded = 1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    job_t rj;
    reset = 1'b0; cfgStart = 1'b0; cfgReloadCoef = 1'b0; cfgNumWindows = '0;
    coefData = '0; coefValid = 1'b0; pixData = '0; pixValid = 1'b0; resReady = 1'b0;
    m_loaded = 0;
    repeat (3) @(negedge clk);
    check("reset_state",
          {coefReady, pixReady, resValid, resData, busy, done, accDataIn, accDataValid, accFilter}, '0);
    reset = 1'b1;

    //         basic rel nwin gap stall xstart abort expcoef
    jobs[0] = '{1, 1, 1,  0,  0, 0, -1, 9};  // basic 0.5 x 1.5..9.5
    jobs[1] = '{0, 0, 2,  0,  0, 0, -1, 0};  // coefficient reuse
    jobs[2] = '{0, 1, 3, 40,  5, 0, -1, 9};  // stalls, reload
    jobs[3] = '{0, 0, 0,  0,  0, 0, -1, 0};  // zero windows
    jobs[4] = '{0, 0, 2, 20,  0, 6, -1, 0};  // start pulse mid-job
    jobs[5] = '{0, 1, 0,  0,  0, 0, -1, 0};  // zero windows skips reload
    jobs[6] = '{0, 0, 4, 30,  2, 0, -1, 0};
    jobs[7] = '{0, 1, 1,  0,  0, 0,  4, 9};  // reset during FEED at tap 4
    jobs[8] = '{0, 0, 1, 10,  1, 0, -1, 9};  // reload forced after reset
    for (int i = 0; i < 9; i++) run_job(jobs[i]);

    for (int i = 0; i < 4; i++) begin
      rj.basic       = 0;
      rj.reload      = bit'($urandom_range(0, 1));
      rj.nwin        = int'($urandom_range(1, 3));
      rj.gap_pct     = int'($urandom_range(0, 50));
      rj.stall       = int'($urandom_range(0, 3));
      rj.extra_start = 0;
      rj.abort_pix   = -1;
      rj.exp_coef    = (rj.reload || !m_loaded) ? 9 : 0;
      run_job(rj);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
